// File: rtl/axistream_pack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axistream_pack_arbiter
// Description : Packet-granular round-robin arbiter feeding one axistream_pack
//               instance; tags beats with the source index and flags packets
//               whose length is not a multiple of the packer ratio.
// Revision    : 1.0 - initial release
// ============================================================================
module axistream_pack_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4,
  parameter int NUM_PACK   = 4,
  parameter int ID_WIDTH   = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_tvalid,
  output logic [NUM_SRC-1:0]            src_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
  input  logic [NUM_SRC-1:0]            src_tlast,
  output logic                          dest_tvalid,
  input  logic                          dest_tready,
  output logic [DATA_WIDTH-1:0]         dest_tdata,
  output logic                          dest_tlast,
  output logic [ID_WIDTH-1:0]           dest_tid,
  output logic                          grant_active,
  output logic                          tlast_align_err
);

  localparam int                  c_cnt_w     = $clog2(NUM_PACK);
  localparam logic [c_cnt_w-1:0]  c_last_beat = c_cnt_w'(NUM_PACK - 1);
  localparam logic [ID_WIDTH-1:0] c_last_src  = ID_WIDTH'(NUM_SRC - 1);

  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_locked = 1'b1;

  logic [0:0]          r_state;
  logic [ID_WIDTH-1:0] r_grant;
  logic [ID_WIDTH-1:0] r_last_grant;
  logic [c_cnt_w-1:0]  r_beat_cnt;
  logic                r_align_err;

  logic [DATA_WIDTH-1:0] w_src_data [NUM_SRC];
  logic [NUM_SRC-1:0]    w_above;
  logic [ID_WIDTH-1:0]   w_pick;
  logic                  w_locked;
  logic                  w_hs;
  logic                  w_last_hs;

  assign w_locked = (r_state == c_st_locked);

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign w_src_data[i] = src_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign w_above[i]    = (ID_WIDTH'(i) > r_last_grant);
      // Ready never looks at src_tvalid, so no valid->ready loop exists.
      assign src_tready[i] = w_locked && (r_grant == ID_WIDTH'(i)) && dest_tready;
    end
  endgenerate

  // Lowest requester above last_grant wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_pick = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_tvalid[i]) begin
        w_pick = ID_WIDTH'(i);
      end
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_tvalid[i] && w_above[i]) begin
        w_pick = ID_WIDTH'(i);
      end
    end
  end

  assign dest_tvalid     = w_locked && src_tvalid[r_grant];
  assign dest_tdata      = w_src_data[r_grant];
  assign dest_tlast      = src_tlast[r_grant];
  assign dest_tid        = r_grant;
  assign grant_active    = w_locked;
  assign tlast_align_err = r_align_err;

  assign w_hs      = dest_tvalid && dest_tready;
  assign w_last_hs = w_hs && dest_tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_grant      <= '0;
      r_last_grant <= c_last_src;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (|src_tvalid) begin
            r_grant <= w_pick;
            r_state <= c_st_locked;
          end
        end
        c_st_locked: begin
          if (w_last_hs) begin
            r_last_grant <= r_grant;
            r_state      <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Position within the current packer word; restarts at every packet boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= w_last_hs && (r_beat_cnt != c_last_beat);
      if (w_last_hs) begin
        r_beat_cnt <= '0;
      end else if (w_hs) begin
        if (r_beat_cnt == c_last_beat) begin
          r_beat_cnt <= '0;
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axistream_pack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axistream_pack_arbiter
// Description : Self-checking bench: packet-level reference model, directed
//               scenarios and randomized traffic for axistream_pack_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axistream_pack_arbiter;

  localparam int DW = 8;
  localparam int NS = 4;
  localparam int NP = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] src_tvalid, src_tready, src_tlast;
  logic [NS*DW-1:0] src_tdata;
  logic          dest_tvalid, dest_tready, dest_tlast;
  logic [DW-1:0] dest_tdata;
  logic [IW-1:0] dest_tid;
  logic          grant_active, tlast_align_err;

  always #5 clk = ~clk;

  axistream_pack_arbiter #(
    .DATA_WIDTH(DW), .NUM_SRC(NS), .NUM_PACK(NP), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .src_tvalid(src_tvalid), .src_tready(src_tready),
    .src_tdata(src_tdata), .src_tlast(src_tlast),
    .dest_tvalid(dest_tvalid), .dest_tready(dest_tready),
    .dest_tdata(dest_tdata), .dest_tlast(dest_tlast), .dest_tid(dest_tid),
    .grant_active(grant_active), .tlast_align_err(tlast_align_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (packet-level view) ----------------
  logic m_locked;
  int   m_grant, m_last, m_len;
  logic m_err;

  function automatic int rr_pick(input logic [NS-1:0] v, input int last);
    for (int k = 1; k <= NS; k++) begin
      if (v[(last + k) % NS]) return (last + k) % NS;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_locked <= 1'b0;
      m_grant  <= 0;
      m_last   <= NS - 1;
      m_len    <= 0;
      m_err    <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (!m_locked) begin
        if (src_tvalid != '0) begin
          m_grant  <= rr_pick(src_tvalid, m_last);
          m_locked <= 1'b1;
        end
      end else if (src_tvalid[m_grant] && dest_tready) begin
        if (src_tlast[m_grant]) begin
          m_err    <= ((m_len + 1) % NP) != 0;
          m_len    <= 0;
          m_locked <= 1'b0;
          m_last   <= m_grant;
        end else begin
          m_len <= m_len + 1;
        end
      end
    end
  end

  function automatic logic [NS-1:0] exp_ready();
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = m_locked && (i == m_grant) && dest_tready;
    return r;
  endfunction

  always @(negedge clk) begin
    chk("grant_active", grant_active, m_locked);
    chk("dest_tvalid", dest_tvalid, m_locked && src_tvalid[m_grant]);
    chk("src_tready", src_tready, exp_ready());
    chk("tlast_align_err", tlast_align_err, m_err);
    if (m_locked && src_tvalid[m_grant]) begin
      chk("dest_tdata", dest_tdata, src_tdata[m_grant*DW +: DW]);
      chk("dest_tlast", dest_tlast, src_tlast[m_grant]);
      chk("dest_tid", dest_tid, m_grant);
    end
  end

  // ---------------- monitor logs ----------------
  int            cyc = 0;
  logic [IW-1:0] rx_tid[$];
  logic [DW-1:0] rx_data[$];
  logic          rx_last[$];
  int            rx_cyc[$];
  int            err_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && dest_tvalid && dest_tready) begin
      rx_tid.push_back(dest_tid);
      rx_data.push_back(dest_tdata);
      rx_last.push_back(dest_tlast);
      rx_cyc.push_back(cyc);
    end
    if (!rst && tlast_align_err) err_cyc.push_back(cyc);
  end

  // ---------------- source / sink drivers ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          is_gap;
  } beat_t;

  beat_t         srcq[NS][$];
  logic [DW-1:0] expq[NS][$];
  int            valid_pct = 100;
  int            ready_pct = 100;
  int            hold      = 0;

  task automatic step();
    logic [NS-1:0] fire;
    @(negedge clk);
    fire = src_tvalid & src_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (fire[i]) void'(srcq[i].pop_front());
      if (src_tvalid[i] && !fire[i]) begin
        // hold the presented beat until it is taken
      end else if (srcq[i].size() == 0) begin
        src_tvalid[i] = 1'b0;
      end else if (srcq[i][0].is_gap) begin
        void'(srcq[i].pop_front());
        src_tvalid[i] = 1'b0;
      end else if ($urandom_range(99) < valid_pct) begin
        src_tvalid[i]           = 1'b1;
        src_tdata[i*DW +: DW]   = srcq[i][0].data;
        src_tlast[i]            = srcq[i][0].last;
      end else begin
        src_tvalid[i] = 1'b0;
      end
    end
    if (hold > 0) begin
      dest_tready = 1'b0;
      hold--;
    end else begin
      dest_tready = ($urandom_range(99) < ready_pct);
    end
  endtask

  task automatic push_pkt(input int s, input int len, input int base,
                          input int gap_after, input int gap_len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = DW'(base + k);
      b.last = (k == len - 1);
      b.is_gap = 1'b0;
      srcq[s].push_back(b);
      if (k == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          b.is_gap = 1'b1;
          srcq[s].push_back(b);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_tvalid = '0;
    src_tlast = '0;
    src_tdata = '0;
    dest_tready = 1'b0;
    hold = 0;
    for (int i = 0; i < NS; i++) begin
      srcq[i].delete();
      expq[i].delete();
    end
    repeat (3) step();
    rx_tid.delete(); rx_data.delete(); rx_last.delete(); rx_cyc.delete();
    err_cyc.delete();
    rst = 1'b0;
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NS; i++) n += srcq[i].size();
    return n;
  endfunction

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((pending() != 0 || grant_active || src_tvalid != '0) && n < bound) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= bound) begin
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
    end
    repeat (2) step();
  endtask

  task automatic wait_rx(input int count, input int bound);
    int n = 0;
    while (rx_data.size() < count && n < bound) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= bound) begin
      n_fail++;
      $display("FAIL rx_timeout: %0d beats seen, expected %0d", rx_data.size(), count);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [DW-1:0] t1_data[4];
    int            ord[5];
    int            total;
    t1_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    ord     = '{0, 1, 2, 3, 0};

    // Reset state
    do_reset();
    #1;
    chk("rst_grant_active", grant_active, 1'b0);
    chk("rst_dest_tvalid", dest_tvalid, 1'b0);
    chk("rst_src_tready", src_tready, 4'b0000);
    chk("rst_align_err", tlast_align_err, 1'b0);

    // Single 4-beat packet from source 0
    push_pkt(0, 4, 8'h11, -1, 0);
    for (int k = 0; k < 4; k++) srcq[0][k].data = t1_data[k];
    step();
    #3 chk("t1_active_before", grant_active, 1'b0);
    step();
    #1 chk("t1_active_after", grant_active, 1'b1);
    wait_drain(200);
    chk("t1_beats", rx_data.size(), 4);
    for (int k = 0; k < 4 && k < rx_data.size(); k++) begin
      chk("t1_data", rx_data[k], t1_data[k]);
      chk("t1_tid", rx_tid[k], 0);
      chk("t1_last", rx_last[k], (k == 3));
    end
    chk("t1_err_pulses", err_cyc.size(), 0);

    // All sources busy: grant order 0,1,2,3,0 with one bubble between packets
    do_reset();
    push_pkt(0, 4, 8'h00, -1, 0);
    push_pkt(0, 4, 8'h04, -1, 0);
    for (int s = 1; s < NS; s++) push_pkt(s, 4, s * 16, -1, 0);
    wait_drain(400);
    chk("t2_beats", rx_data.size(), 20);
    for (int j = 0; j < 5 && 4 * j + 3 < rx_data.size(); j++) begin
      for (int k = 0; k < 4; k++) begin
        chk("t2_tid", rx_tid[4*j+k], ord[j]);
        chk("t2_data", rx_data[4*j+k], ord[j] * 16 + ((j == 4) ? 4 : 0) + k);
        if (k > 0) chk("t2_back_to_back", rx_cyc[4*j+k] - rx_cyc[4*j+k-1], 1);
      end
      if (j > 0) chk("t2_bubble", rx_cyc[4*j] - rx_cyc[4*j-1], 2);
    end

    // Source 2 stalls mid-packet while source 1 waits
    do_reset();
    push_pkt(2, 4, 8'h20, 1, 3);
    step();
    step();
    push_pkt(1, 4, 8'h10, -1, 0);
    wait_drain(400);
    chk("t3_beats", rx_data.size(), 8);
    for (int k = 0; k < 8 && k < rx_data.size(); k++) begin
      chk("t3_tid", rx_tid[k], (k < 4) ? 2 : 1);
      chk("t3_data", rx_data[k], (k < 4) ? (8'h20 + k) : (8'h10 + k - 4));
    end
    if (rx_cyc.size() >= 3) chk("t3_stall_gap", rx_cyc[2] - rx_cyc[1], 4);

    // Misaligned 6-beat packet then aligned 8-beat packet
    do_reset();
    push_pkt(3, 6, 8'h30, -1, 0);
    push_pkt(3, 8, 8'h40, -1, 0);
    wait_drain(400);
    chk("t4_beats", rx_data.size(), 14);
    chk("t4_err_pulses", err_cyc.size(), 1);
    if (err_cyc.size() >= 1 && rx_cyc.size() >= 6)
      chk("t4_err_timing", err_cyc[0], rx_cyc[5] + 1);

    // Downstream backpressure for 5 cycles mid-packet
    do_reset();
    push_pkt(0, 8, 8'h00, -1, 0);
    wait_rx(3, 100);
    dest_tready = 1'b0;
    hold = 4;
    step();
    step();
    #1;
    chk("t5_stall_ready", src_tready, 4'b0000);
    chk("t5_stall_valid", dest_tvalid, 1'b1);
    chk("t5_stall_data", dest_tdata, 8'h03);
    wait_drain(200);
    chk("t5_beats", rx_data.size(), 8);
    for (int k = 0; k < 8 && k < rx_data.size(); k++) chk("t5_data", rx_data[k], k);

    // Asynchronous reset after beat 2 of source 0, source 1 also requesting
    do_reset();
    push_pkt(0, 4, 8'hA0, -1, 0);
    push_pkt(1, 4, 8'hB0, -1, 0);
    wait_rx(2, 100);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_active", grant_active, 1'b0);
    chk("t6_rst_ready", src_tready, 4'b0000);
    chk("t6_rst_valid", dest_tvalid, 1'b0);
    step();
    step();
    rst = 1'b0;
    wait_drain(200);
    chk("t6_beats", rx_data.size(), 8);
    if (rx_data.size() >= 5) begin
      chk("t6_resume_tid", rx_tid[2], 0);
      chk("t6_resume_data", rx_data[2], 8'hA2);
      chk("t6_resume_last", rx_last[3], 1'b1);
      chk("t6_resume_tail", rx_data[3], 8'hA3);
      chk("t6_next_tid", rx_tid[4], 1);
      chk("t6_next_data", rx_data[4], 8'hB0);
    end
    chk("t6_err_pulses", err_cyc.size(), 1);

    // Randomized traffic with throttled sources and sink
    do_reset();
    valid_pct = 70;
    ready_pct = 70;
    total = 0;
    for (int s = 0; s < NS; s++) begin
      int npkt = $urandom_range(2, 4);
      for (int p = 0; p < npkt; p++) begin
        int len = $urandom_range(1, 9);
        int base = $urandom_range(0, 255);
        push_pkt(s, len, base, $urandom_range(0, len - 1), $urandom_range(0, 2));
        for (int k = 0; k < len; k++) expq[s].push_back(DW'(base + k));
        total += len;
      end
    end
    wait_drain(5000);
    chk("rand_beats", rx_data.size(), total);
    for (int j = 0; j < rx_data.size(); j++) begin
      if (expq[rx_tid[j]].size() > 0) chk("rand_data", rx_data[j], expq[rx_tid[j]].pop_front());
      else chk("rand_extra_beat", rx_tid[j], 4'hF);
      if (j > 0 && !rx_last[j-1]) chk("rand_contiguous", rx_tid[j], rx_tid[j-1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axistream_pack_arbiter.md
Name: axistream_pack_arbiter

Overview:
- Round-robin arbiter that shares one axistream_pack instance between NUM_SRC narrow AXI-stream sources.
- Grants one source at a time and holds the grant for a whole packet (until the tlast handshake).
- Forwards the granted source's beats to the packer input unchanged and tags each beat with the source index.
- Checks that each packet length is a multiple of NUM_PACK, which is the packer's tlast alignment rule.

Parameters:
DATA_WIDTH, 8, width of one source beat
NUM_SRC, 4, number of requesting sources (>=2)
NUM_PACK, 4, packer ratio; packet lengths must be a multiple of this (>=2)
ID_WIDTH, $clog2(NUM_SRC), width of dest_tid

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
src_tvalid  in  NUM_SRC  per-source valid
src_tready  out  NUM_SRC  per-source ready
src_tdata  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
src_tlast  in  NUM_SRC  per-source end of packet
dest_tvalid  out  1  to packer src_tvalid
dest_tready  in  1  from packer src_tready
dest_tdata  out  DATA_WIDTH  granted source's data
dest_tlast  out  1  granted source's tlast
dest_tid  out  ID_WIDTH  index of granted source
grant_active  out  1  high while in LOCKED
tlast_align_err  out  1  one-cycle pulse when a packet ends off a NUM_PACK boundary

Behaviour:
- Reset: one clock domain; rst is asynchronous and active-high. While rst is high and after it deasserts:
  - state=IDLE, grant=0, last_grant=NUM_SRC-1 (source 0 wins first), beat_cnt=0, tlast_align_err=0.
  - All src_tready=0, dest_tvalid=0, grant_active=0.
- States:
  - IDLE: if any src_tvalid is high, latch grant = first i with src_tvalid[i] high, searching from (last_grant+1) mod NUM_SRC upward with wrap. Go to LOCKED next cycle. No data passes during IDLE.
  - LOCKED: combinational pass-through, zero latency:
    - dest_tvalid = src_tvalid[grant]
    - dest_tdata = src_tdata slice[grant]
    - dest_tlast = src_tlast[grant]
    - dest_tid = grant
    - src_tready[grant] = dest_tready; all other src_tready = 0
  - LOCKED -> IDLE on dest_tvalid && dest_tready && dest_tlast. last_grant <= grant on that edge.
- Arbitration timing and fairness:
  - One bubble cycle (IDLE) between packets. Sustained throughput with single-beat packets is 1/2 beat per cycle.
  - A source that drops tvalid mid-packet keeps the grant; the arbiter waits indefinitely.
  - Sources that are not requesting are skipped without costing a cycle.
- dest_tid, dest_tdata and dest_tlast are don't-care when dest_tvalid=0. The implementation drives dest_tid=grant at all times.
- Beat counter:
  - beat_cnt (width $clog2(NUM_PACK)) increments mod NUM_PACK on each dest handshake.
  - It resets to 0 on a tlast handshake.
- Alignment error:
  - tlast_align_err is registered. It is 1 in the cycle after a tlast handshake when beat_cnt != NUM_PACK-1 at that handshake, and 0 otherwise.
  - The packet is still forwarded in full and the grant is released normally.
- Reset mid-packet:
  - The grant is dropped and the state returns to IDLE immediately.
  - The remainder of the interrupted packet is arbitrated later as a new packet. Downstream flush is the integrator's responsibility.
- No combinational path from src_tvalid to src_tready. src_tready depends only on state, grant and dest_tready.

Test Plan:
- Reset, then src_tvalid=4'b0001, 4-beat packet 0x11,0x22,0x33,0x44 with tlast on beat 4, dest_tready=1:
  - grant_active rises 1 cycle after tvalid.
  - dest sees 4 beats, dest_tid=0, tlast on beat 4.
  - tlast_align_err stays 0.
- All 4 sources hold 4-beat packets continuously:
  - Grant order is 0,1,2,3,0.
  - Exactly one IDLE cycle between packets.
  - Packets from different sources never interleave.
- Source 2 sends 4 beats, deasserting tvalid for 3 cycles after beat 2; source 1 requests meanwhile:
  - Grant stays on 2 until its tlast.
  - Source 1 is granted next, and src_tready[1]=0 until then.
- Source 3 sends a 6-beat packet with NUM_PACK=4:
  - tlast_align_err=1 for exactly one cycle after the tlast handshake.
  - The next 8-beat packet gives err=0.
- dest_tready held low for 5 cycles mid-packet:
  - src_tready[grant]=0 for those cycles and the data stays stable.
  - No beat is lost or duplicated (compare the 8-beat sequence 0x00..0x07).
- Assert rst asynchronously between clock edges after beat 2 of source 0's packet, while source 1 is also requesting:
  - Outputs drop immediately.
  - After release, source 0 is granted first and its remaining beats appear as a new packet.
